// File: rtl/ifu_prefetch_if.sv
// Bus bundle for the instruction-fetch front end: imem request/response,
// execute-stage redirect, and the decode-facing instruction stream.
interface ifu_prefetch_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic [CW-1:0] inflight;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, inflight,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, inflight,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: issues sequential word fetches under a credit limit,
// buffers returned words with their PCs, and flushes on execute-stage redirects.
module ifu_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  ifu_prefetch_if.master bus
);
  localparam int unsigned   AW  = $clog2(DEPTH);
  localparam int unsigned   CW  = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] pend;
  logic [CW-1:0] drop;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          deq;
  logic          keep;
  logic          dropping;
  logic [1:0]    unused_pc_lsb;

  assign unused_pc_lsb = bus.redirect_pc[1:0];

  // Buffered plus kept-in-flight words never exceed DEPTH, so every kept
  // response is guaranteed a FIFO slot and responses need no backpressure.
  assign credit_used        = {1'b0, count} + {1'b0, pend};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (credit_used < CAP);
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = !rst && (count != '0) && !bus.redirect_valid;
  assign bus.out_inst       = fifo_inst[rd_ptr];
  assign bus.out_pc         = fifo_pc[rd_ptr];
  assign bus.inflight       = pend + drop;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign deq      = bus.out_valid && bus.out_ready;
  assign dropping = bus.imem_resp_valid && (drop != '0);
  assign keep     = bus.imem_resp_valid && (drop == '0) && !bus.redirect_valid;

  // Kept responses are PC-contiguous from the last restart point, so a single
  // running response PC replaces a per-request tag queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pend     <= '0;
      drop     <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      resp_pc  <= {bus.redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pend     <= '0;
      drop     <= drop + pend - CW'(bus.imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (dropping) drop <= drop - CW'(1);
      if (keep) begin
        fifo_pc[wr_ptr]   <= resp_pc;
        fifo_inst[wr_ptr] <= bus.imem_resp_data;
        wr_ptr            <= wr_ptr + AW'(1);
        resp_pc           <= resp_pc + 32'd4;
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      pend  <= pend + CW'(req_fire) - CW'(keep);
      count <= count + CW'(keep) - CW'(deq);
    end
  end

  // A response with nothing outstanding would underflow the drop/pend counters.
  assert property (@(posedge clk) disable iff (rst)
    bus.imem_resp_valid |-> (bus.inflight != '0));
endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised and directed bench for ifu_prefetch against a queue-based model
// of the fetch stream, in-flight requests and the instruction buffer.
module tb_ifu_prefetch;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_prefetch_if #(.DEPTH(DEPTH)) bus ();
  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] addr; int unsigned due; bit keep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t          os[$];
  ent_t          fq[$];
  logic [31:0]   m_pc;
  int unsigned   cyc, lat;
  int            checks, failures;
  logic          resp_now;
  logic          e_req_valid, e_out_valid;
  logic [31:0]   e_addr, e_pc, e_inst;
  logic [CW-1:0] e_inflight;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0F00;
  endfunction

  // Drive one cycle's inputs (memory response comes from the model) and
  // derive the expected DUT outputs for this cycle.
  task automatic apply(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic ordy, input logic rqr, input logic stall);
    int kept;
    kept = 0;
    rst = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ordy;
    bus.imem_req_ready = rqr;
    resp_now = (os.size() > 0) && !stall;
    if (resp_now) resp_now = (os[0].due <= cyc);
    bus.imem_resp_valid = resp_now;
    bus.imem_resp_data  = resp_now ? memword(os[0].addr) : $urandom;
    foreach (os[i]) if (os[i].keep) kept++;
    e_req_valid = !r && !rv && ((fq.size() + kept) < DEPTH);
    e_out_valid = !r && !rv && (fq.size() > 0);
    e_addr      = m_pc;
    e_inflight  = CW'(os.size());
    e_pc        = (fq.size() > 0) ? fq[0].pc : 32'h0;
    e_inst      = (fq.size() > 0) ? fq[0].inst : 32'h0;
    #1;
  endtask

  // Advance the model across the clock edge using only the driven inputs.
  task automatic tick();
    req_t q;
    @(posedge clk);
    if (rst) begin
      os.delete();
      fq.delete();
      m_pc = RST_PC;
    end else if (bus.redirect_valid) begin
      if (resp_now) q = os.pop_front();
      fq.delete();
      foreach (os[i]) os[i].keep = 1'b0;
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (e_out_valid && bus.out_ready) void'(fq.pop_front());
      if (resp_now) begin
        q = os.pop_front();
        if (q.keep) fq.push_back('{pc: q.addr, inst: memword(q.addr)});
      end
      if (e_req_valid && bus.imem_req_ready) begin
        os.push_back('{addr: m_pc, due: cyc + lat, keep: 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.inflight !== '0) begin failures++; $display("FAIL reset inflight got=%0d exp=0", bus.inflight); end
    checks++; if (bus.imem_req_addr !== RST_PC) begin failures++; $display("FAIL reset req_addr got=%h exp=%h", bus.imem_req_addr, RST_PC); end
    tick();
  endtask

  task automatic test_stream();
    lat = 1;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++; if (bus.imem_req_valid !== e_req_valid) begin failures++; $display("FAIL stream req_valid got=%b exp=%b cyc=%0d", bus.imem_req_valid, e_req_valid, cyc); end
      checks++; if (bus.out_valid !== e_out_valid) begin failures++; $display("FAIL stream out_valid got=%b exp=%b cyc=%0d", bus.out_valid, e_out_valid, cyc); end
      checks++; if (bus.inflight !== e_inflight) begin failures++; $display("FAIL stream inflight got=%0d exp=%0d cyc=%0d", bus.inflight, e_inflight, cyc); end
      if (e_req_valid) begin checks++; if (bus.imem_req_addr !== e_addr) begin failures++; $display("FAIL stream req_addr got=%h exp=%h cyc=%0d", bus.imem_req_addr, e_addr, cyc); end end
      if (k >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * (k - 2)) || bus.out_inst !== memword(32'(4 * (k - 2)))) begin
          failures++; $display("FAIL stream seq got=%b/%h/%h exp=1/%h/%h", bus.out_valid, bus.out_pc, bus.out_inst, 32'(4 * (k - 2)), memword(32'(4 * (k - 2))));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int accepted, drained;
    bit seen;
    accepted = 0; drained = 0; seen = 1'b0;
    lat = 1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.imem_req_valid !== e_req_valid) begin failures++; $display("FAIL bp req_valid got=%b exp=%b cyc=%0d", bus.imem_req_valid, e_req_valid, cyc); end
      checks++; if (bus.inflight !== e_inflight) begin failures++; $display("FAIL bp inflight got=%0d exp=%0d cyc=%0d", bus.inflight, e_inflight, cyc); end
      if (e_req_valid) begin checks++; if (bus.imem_req_addr !== e_addr) begin failures++; $display("FAIL bp req_addr got=%h exp=%h cyc=%0d", bus.imem_req_addr, e_addr, cyc); end end
      if (bus.imem_req_valid === 1'b1) accepted++;
      tick();
    end
    checks++; if (accepted != DEPTH) begin failures++; $display("FAIL bp issued got=%0d exp=%0d", accepted, DEPTH); end
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++; if (bus.out_valid !== e_out_valid) begin failures++; $display("FAIL bp out_valid got=%b exp=%b cyc=%0d", bus.out_valid, e_out_valid, cyc); end
      if (e_out_valid) begin checks++; if (bus.out_pc !== e_pc || bus.out_inst !== e_inst) begin failures++; $display("FAIL bp head got=%h/%h exp=%h/%h cyc=%0d", bus.out_pc, bus.out_inst, e_pc, e_inst, cyc); end end
      if (bus.out_valid === 1'b1) begin
        checks++; if (bus.out_pc !== 32'(4 * drained)) begin failures++; $display("FAIL bp order got=%h exp=%h", bus.out_pc, 32'(4 * drained)); end
        drained++;
      end
      if (bus.imem_req_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++; if (bus.imem_req_addr !== 32'h10) begin failures++; $display("FAIL bp resume_addr got=%h exp=00000010", bus.imem_req_addr); end
      end
      tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL bp resume got=none exp=request within 16 cycles"); end
  endtask

  task automatic test_redirect_drop();
    bit seen_req, seen_out;
    seen_req = 1'b0; seen_out = 1'b0;
    lat = 3;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    apply(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.inflight !== CW'(2)) begin failures++; $display("FAIL redir inflight_before got=%0d exp=2", bus.inflight); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir req_valid got=%b exp=0", bus.imem_req_valid); end
    tick();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.inflight !== e_inflight) begin failures++; $display("FAIL redir inflight got=%0d exp=%0d cyc=%0d", bus.inflight, e_inflight, cyc); end
      checks++; if (bus.out_valid !== e_out_valid) begin failures++; $display("FAIL redir out_valid got=%b exp=%b cyc=%0d", bus.out_valid, e_out_valid, cyc); end
      tick();
    end
    apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.inflight !== '0) begin failures++; $display("FAIL redir drained got=%0d exp=0", bus.inflight); end
    for (int k = 0; k < 20 && !seen_out; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (bus.imem_req_valid === 1'b1 && !seen_req) begin
        seen_req = 1'b1;
        checks++; if (bus.imem_req_addr !== 32'h100) begin failures++; $display("FAIL redir new_addr got=%h exp=00000100", bus.imem_req_addr); end
      end
      if (bus.out_valid === 1'b1) begin
        seen_out = 1'b1;
        checks++; if (bus.out_pc !== 32'h100 || bus.out_inst !== memword(32'h100)) begin failures++; $display("FAIL redir first_out got=%h/%h exp=00000100/%h", bus.out_pc, bus.out_inst, memword(32'h100)); end
      end
      tick();
    end
    checks++; if (!seen_out) begin failures++; $display("FAIL redir timeout got=no output exp=output within 20 cycles"); end
  endtask

  task automatic test_redirect_collision();
    bit seen_out;
    seen_out = 1'b0;
    lat = 1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    apply(1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL coll out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL coll req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.inflight !== e_inflight) begin failures++; $display("FAIL coll inflight got=%0d exp=%0d", bus.inflight, e_inflight); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL coll empty got=%b exp=0", bus.out_valid); end
    checks++; if (bus.inflight !== e_inflight) begin failures++; $display("FAIL coll inflight_after got=%0d exp=%0d", bus.inflight, e_inflight); end
    tick();
    for (int k = 0; k < 12 && !seen_out; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++; if (bus.out_valid !== e_out_valid) begin failures++; $display("FAIL coll out_valid_run got=%b exp=%b cyc=%0d", bus.out_valid, e_out_valid, cyc); end
      if (e_req_valid) begin checks++; if (bus.imem_req_addr !== e_addr) begin failures++; $display("FAIL coll req_addr got=%h exp=%h cyc=%0d", bus.imem_req_addr, e_addr, cyc); end end
      if (bus.out_valid === 1'b1) begin
        seen_out = 1'b1;
        checks++; if (bus.out_pc !== 32'h2000) begin failures++; $display("FAIL coll first_out got=%h exp=00002000", bus.out_pc); end
      end
      tick();
    end
    checks++; if (!seen_out) begin failures++; $display("FAIL coll timeout got=no output exp=output within 12 cycles"); end
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset();
    apply(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap addr0 got=%h exp=fffffffc", bus.imem_req_addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap addr1 got=%h exp=00000000", bus.imem_req_addr); end
    tick();
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++; if (bus.out_valid !== e_out_valid) begin failures++; $display("FAIL wrap out_valid got=%b exp=%b cyc=%0d", bus.out_valid, e_out_valid, cyc); end
      if (e_out_valid) begin checks++; if (bus.out_pc !== e_pc || bus.out_inst !== e_inst) begin failures++; $display("FAIL wrap head got=%h/%h exp=%h/%h cyc=%0d", bus.out_pc, bus.out_inst, e_pc, e_inst, cyc); end end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    lat = 1;
    do_reset();
    for (int k = 0; k < 12 && fq.size() < 3; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL midrst prefill got=%b exp=1", bus.out_valid); end
    apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst during got=%b/%b exp=0/0", bus.out_valid, bus.imem_req_valid); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.inflight !== '0) begin failures++; $display("FAIL midrst inflight got=%0d exp=0", bus.inflight); end
    checks++; if (bus.imem_req_addr !== RST_PC) begin failures++; $display("FAIL midrst req_addr got=%h exp=%h", bus.imem_req_addr, RST_PC); end
    for (int k = 0; k < 6; k++) begin
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      checks++; if (bus.out_valid !== e_out_valid) begin failures++; $display("FAIL midrst out_valid_run got=%b exp=%b cyc=%0d", bus.out_valid, e_out_valid, cyc); end
      if (e_out_valid) begin checks++; if (bus.out_pc !== e_pc || bus.out_inst !== e_inst) begin failures++; $display("FAIL midrst head got=%h/%h exp=%h/%h cyc=%0d", bus.out_pc, bus.out_inst, e_pc, e_inst, cyc); end end
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      lat = $urandom_range(1, 3);
      apply(($urandom % 150) == 0, ($urandom % 14) == 0, $urandom,
            ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 5) == 0);
      checks++; if (bus.imem_req_valid !== e_req_valid) begin failures++; $display("FAIL rand req_valid got=%b exp=%b cyc=%0d", bus.imem_req_valid, e_req_valid, cyc); end
      checks++; if (bus.out_valid !== e_out_valid) begin failures++; $display("FAIL rand out_valid got=%b exp=%b cyc=%0d", bus.out_valid, e_out_valid, cyc); end
      checks++; if (bus.inflight !== e_inflight) begin failures++; $display("FAIL rand inflight got=%0d exp=%0d cyc=%0d", bus.inflight, e_inflight, cyc); end
      if (e_req_valid) begin checks++; if (bus.imem_req_addr !== e_addr) begin failures++; $display("FAIL rand req_addr got=%h exp=%h cyc=%0d", bus.imem_req_addr, e_addr, cyc); end end
      if (e_out_valid) begin checks++; if (bus.out_pc !== e_pc || bus.out_inst !== e_inst) begin failures++; $display("FAIL rand head got=%h/%h exp=%h/%h cyc=%0d", bus.out_pc, bus.out_inst, e_pc, e_inst, cyc); end end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=still running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; lat = 1; m_pc = RST_PC; resp_now = 1'b0;
    rst = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.out_ready       = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
